// File: rtl/sram_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
package sram_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 16;
    localparam int BURST_W    = 4;

endpackage

// File: rtl/sram_arb_sel.sv
// Grant selection: last owner and burst tracking, tie policy.
// SRAM_ARB_RR_EN selects burst-limited round robin; default is CPU priority.
module sram_arb_sel
    import sram_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_sel,
    output logic dma_sel
);

    localparam logic [BURST_W-1:0] MAXB = BURST_W'(MAX_BURST);

    owner_e               last_q, last_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    owner_e               own;

    always_comb begin
        cpu_sel = 1'b0;
        dma_sel = 1'b0;
        if (rst) begin
            if (cpu_req && dma_req) begin
`ifdef SRAM_ARB_RR_EN
                // A zero count means no history yet, so the tie goes away from last_owner
                if (burst_q == '0 || burst_q >= MAXB) begin
                    cpu_sel = (last_q == OWN_DMA);
                    dma_sel = (last_q == OWN_CPU);
                end else begin
                    cpu_sel = (last_q == OWN_CPU);
                    dma_sel = (last_q == OWN_DMA);
                end
`else
                cpu_sel = 1'b1;
`endif
            end else begin
                cpu_sel = cpu_req;
                dma_sel = dma_req;
            end
        end
    end

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        own     = cpu_sel ? OWN_CPU : OWN_DMA;
        if (cpu_sel || dma_sel) begin
            if (own == last_q && burst_q != '0) begin
                if (burst_q < MAXB) burst_d = burst_q + 1'b1;
            end else begin
                last_d  = own;
                burst_d = BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= OWN_DMA;
            burst_q <= '0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single-port synchronous SRAM.
// Tie policy set by SRAM_ARB_RR_EN (see sram_arb_sel).
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic             cpu_rd_q, cpu_rd_d;
    logic             dma_rd_q, dma_rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             refused;

    sram_arb_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_sel (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .cpu_sel (cpu_gnt),
        .dma_sel (dma_gnt)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end
    end

    // One pending-read flag per requester routes the next-cycle SRAM data
    always_comb begin
        cpu_rd_d = cpu_gnt && !cpu_we;
        dma_rd_d = dma_gnt && !dma_we;
        refused  = (cpu_req && !cpu_gnt) || (dma_req && !dma_gnt);
        cnt_d    = cnt_q;
        if (refused && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rd_q <= 1'b0;
            dma_rd_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cpu_rd_q <= cpu_rd_d;
            dma_rd_q <= dma_rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu_rvalid   = cpu_rd_q;
    assign dma_rvalid   = dma_rd_q;
    assign cpu_rdata    = cpu_rd_q ? mem_rdata : '0;
    assign dma_rdata    = dma_rd_q ? mem_rdata : '0;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small synchronous SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [15:0] cpu_rdata, dma_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [15:0] conflict_cnt;

    logic [15:0] sram [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= sram[mem_addr[7:0]];
    end

    sram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_gnt      (dma_gnt),
        .dma_rvalid   (dma_rvalid),
        .dma_rdata    (dma_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0;
        cpu_we  = 1'b0; dma_we  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic exp_cpu;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (2) @(negedge clk);

        // reset holds everything at zero even with requests up
        cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 16'h0005;
        cpu_we = 1'b1; dma_we = 1'b1;
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);

        // tie held 12 cycles starting in the first cycle after release
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_cpu = (i < 4) || (i >= 8);
`else
            exp_cpu = 1'b1;
`endif
            #1;
            chk($sformatf("tie_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(exp_cpu));
            chk($sformatf("tie_dma_gnt%0d", i), 32'(dma_gnt), 32'(!exp_cpu));
            @(negedge clk);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        #1;
        chk("tie_cnt", 32'(conflict_cnt), 32'd12);

        // CPU-only write then read
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h0010; cpu_wdata = 16'h00A5;
        #1;
        chk("wr_gnt", 32'(cpu_gnt), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0010);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h00A5);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("rd_gnt", 32'(cpu_gnt), 32'h1);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h00A5);
        chk("rd_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("idle_mem_addr", 32'(mem_addr), 32'h0);
        chk("rd_cnt", 32'(conflict_cnt), 32'h0);

        // preload two words through the arbiter, then alternate reads
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h0001; cpu_wdata = 16'h1111;
        @(negedge clk);
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1;
        dma_addr = 16'h0002; dma_wdata = 16'h2222;
        @(negedge clk);
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        #1;
        chk("alt_cpu_gnt", 32'(cpu_gnt), 32'h1);
        @(negedge clk);
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002;
        #1;
        chk("alt_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("alt_cpu_rdata", 32'(cpu_rdata), 32'h1111);
        chk("alt_dma_gnt", 32'(dma_gnt), 32'h1);
        chk("alt_dma_rv0", 32'(dma_rvalid), 32'h0);
        @(negedge clk);
        dma_req = 1'b0;
        #1;
        chk("alt_dma_rvalid", 32'(dma_rvalid), 32'h1);
        chk("alt_dma_rdata", 32'(dma_rdata), 32'h2222);
        chk("alt_cpu_rv1", 32'(cpu_rvalid), 32'h0);
        chk("alt_cpu_rdata0", 32'(cpu_rdata), 32'h0);
        @(negedge clk);
        #1;
        chk("alt_dma_rv2", 32'(dma_rvalid), 32'h0);
        chk("alt_dma_rdata0", 32'(dma_rdata), 32'h0);
        chk("alt_cnt", 32'(conflict_cnt), 32'h0);

        // reset asserted mid-cycle right after a CPU read grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("mid_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("mid_cpu_gnt", 32'(cpu_gnt), 32'h0);
        chk("mid_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
        #1;
        chk("post_cpu_gnt", 32'(cpu_gnt), 32'h1);
        chk("post_dma_gnt", 32'(dma_gnt), 32'h0);
        chk("post_cpu_rv", 32'(cpu_rvalid), 32'h0);
        @(negedge clk);
        #1;
        chk("post_cpu_rv2", 32'(cpu_rvalid), 32'h0);

        // saturation of the conflict counter
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1;
        cpu_we = 1'b1; dma_we = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
        repeat (70000 - 65534) @(posedge clk);
        #1;
        chk("sat_ffff", 32'(conflict_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one requester while the other waits (range 1..15).
REQ-004 Port clk, input, 1, single clock; all state on rising edge.
REQ-005 Port rst, input, 1, reset, asynchronous, active-low.
REQ-006 Ports cpu_req, cpu_we, input, 1 each, CPU access request and write-enable.
REQ-007 Ports cpu_addr (ADDR_W) and cpu_wdata (DATA_W), input, CPU address and write data.
REQ-008 Ports cpu_gnt, output, 1; cpu_rvalid, output, 1; cpu_rdata, output, DATA_W; CPU grant and read return.
REQ-009 Ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata SHALL mirror the CPU ports for the loader requester.
REQ-010 Ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_we (1), output; mem_rdata (DATA_W), input; single-port synchronous SRAM side.
REQ-011 Port conflict_cnt, output, 16, saturating count of cycles in which a requester was refused.

Function
REQ-012 Grant is combinational: at most one of cpu_gnt/dma_gnt high per cycle, and a gnt is high only if the matching req is high.
REQ-013 mem_addr/mem_wdata/mem_we SHALL equal the granted requester's addr/wdata/we in the grant cycle; with no grant, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-014 Requesters hold req, we, addr, wdata stable until gnt; the arbiter never grants twice for one request without req staying high.
REQ-015 Read latency is 1: a granted read (we=0) in cycle N SHALL produce <x>_rvalid=1 and <x>_rdata=mem_rdata in cycle N+1 for that requester only.
REQ-016 A granted write produces no rvalid; rdata outputs are 0 whenever rvalid is 0.
REQ-017 State: last_owner register (CPU/DMA) and burst counter (4 bits) recording consecutive grants to last_owner.
REQ-018 Single requester: granted every cycle, regardless of burst count.
REQ-019 Both requesting: arbitration per REQ-027/REQ-028; burst counter increments on repeat grant to last_owner, resets to 1 on owner change.
REQ-020 conflict_cnt increments by 1 in each cycle where at least one req is high without gnt; it holds at 16'hFFFF.
REQ-021 Back-to-back reads by alternating requesters SHALL return each rvalid to the correct requester with no lost or duplicated beat.

Reset
REQ-022 While rst=0: all gnt, rvalid, mem_we =0; rdata, mem_addr, mem_wdata, conflict_cnt =0; last_owner=DMA (so CPU wins first tie); burst counter=0.
REQ-023 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset release.
REQ-024 Reset release SHALL allow a grant in the first cycle rst=1.

Configuration
REQ-025 Macro SRAM_ARB_RR_EN selects the tie policy; nothing else changes.
REQ-026 Port list and parameters are identical with and without the macro.
REQ-027 With SRAM_ARB_RR_EN: on tie, last_owner keeps the grant until burst counter reaches MAX_BURST, then the other requester is granted.
REQ-028 Without SRAM_ARB_RR_EN: fixed priority, CPU always wins ties; MAX_BURST unused.

Structure
REQ-029 Shared package sram_pkg SHALL hold the owner enum (OWN_CPU, OWN_DMA), ADDR_W/DATA_W defaults and conflict counter width.
REQ-030 Tie-break logic (last_owner, burst counter, RR/priority selection) SHALL be one sub-module sram_arb_sel; datapath muxing and rvalid routing stay in sram_arbiter.

Verification
REQ-031 CPU-only write 16'h00A5 to 16'h0010, then read 16'h0010 -> cpu_gnt each cycle, mem_we=1 then 0, cpu_rvalid=1 with cpu_rdata=16'h00A5 one cycle after read grant, conflict_cnt=0.
REQ-032 Both req held 12 cycles, RR, MAX_BURST=4 -> grant pattern CPU x4, DMA x4, CPU x4; conflict_cnt=12.
REQ-033 Same stimulus without SRAM_ARB_RR_EN -> cpu_gnt all 12 cycles, dma_gnt never, conflict_cnt=12.
REQ-034 Alternating reads CPU@0x0001, DMA@0x0002 preloaded 16'h1111/16'h2222 -> cpu_rdata=16'h1111 then dma_rdata=16'h2222, each rvalid exactly one cycle.
REQ-035 Assert rst=0 mid-cycle right after a CPU read grant -> outputs zero immediately, no cpu_rvalid after release, first post-reset tie granted to CPU.
REQ-036 Force 70000 conflict cycles -> conflict_cnt saturates at 16'hFFFF, no wrap.
